// File: rtl/tt_sweep_pkg.sv
// -----------------------------------------------------------------------------
// tt_sweep_pkg
// Shared types and sizing for the truth-table sweep stage.
//   tt_state_t : sweep FSM states (IDLE, DRIVE, SAMPLE, DONE)
//   TT_NUM_VEC : number of input vectors of the 3-input block
//   TT_IDX_W   : width of the vector index
//   TT_CNT_W   : width of the settle counter
// -----------------------------------------------------------------------------
package tt_sweep_pkg;

    localparam int TT_NUM_VEC = 8;
    localparam int TT_IDX_W   = 3;
    localparam int TT_CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } tt_state_t;

endpackage : tt_sweep_pkg

// File: rtl/tt_settle_cnt.sv
// -----------------------------------------------------------------------------
// tt_settle_cnt
// Settle counter: counts the cycles a vector has been held on the block.
//   clk     in  : clock, rising edge
//   rst_n   in  : asynchronous active-low reset
//   clear   in  : synchronous clear to 0 (has priority over enable)
//   enable  in  : increment by one this cycle
//   expired out : count has reached SETTLE_CYCLES-1
// Parameter SETTLE_CYCLES (1..15): hold time per vector in cycles.
// -----------------------------------------------------------------------------
module tt_settle_cnt
    import tt_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TT_CNT_W-1:0] LAST_CNT = TT_CNT_W'(SETTLE_CYCLES - 1);

    logic [TT_CNT_W-1:0] cnt_q;
    logic [TT_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + TT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST_CNT);

endmodule : tt_settle_cnt

// File: rtl/tt_sweep.sv
// -----------------------------------------------------------------------------
// tt_sweep
// Stimulus/capture stage for the 3-input, 2-output combinational lab block.
// Steps {I1,I2,I3} through vectors 0..7, holds each for SETTLE_CYCLES cycles,
// samples O1/O2 in a one-cycle SAMPLE state and builds two 8-bit truth tables.
//   clk, rst_n      in  : clock (rising edge), asynchronous active-low reset
//   start           in  : begin a sweep (honoured in IDLE/DONE only)
//   I1, I2, I3      out : registered drive vector, {I1,I2,I3} == idx
//   O1, O2          in  : block responses
//   idx             out : current vector index
//   busy            out : high in DRIVE/SAMPLE
//   done            out : high in DONE, until the next start or reset
//   tt_o1, tt_o2    out : captured truth tables (bit i = response to vector i)
//   mismatch        out : golden-table comparison result
// Optional feature, macro TT_SWEEP_CHECK_EN: compares the final tables with
// EXP_O1/EXP_O2 on entry to DONE. Without it mismatch is tied 0.
// -----------------------------------------------------------------------------
module tt_sweep
    import tt_sweep_pkg::*;
#(
    parameter int                    SETTLE_CYCLES = 1,
    parameter logic [TT_NUM_VEC-1:0] EXP_O1        = 8'hE8,
    parameter logic [TT_NUM_VEC-1:0] EXP_O2        = 8'h69
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  I1,
    output logic                  I2,
    output logic                  I3,
    input  logic                  O1,
    input  logic                  O2,
    output logic [TT_IDX_W-1:0]   idx,
    output logic                  busy,
    output logic                  done,
    output logic [TT_NUM_VEC-1:0] tt_o1,
    output logic [TT_NUM_VEC-1:0] tt_o2,
    output logic                  mismatch
);

    localparam logic [TT_IDX_W-1:0] LAST_IDX = TT_IDX_W'(TT_NUM_VEC - 1);

    tt_state_t             state_q, state_d;
    logic [TT_IDX_W-1:0]   idx_q, idx_d;
    logic [TT_NUM_VEC-1:0] tt_o1_q, tt_o1_d;
    logic [TT_NUM_VEC-1:0] tt_o2_q, tt_o2_d;
    logic                  cnt_clear;
    logic                  cnt_enable;
    logic                  cnt_expired;

    tt_settle_cnt #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .expired (cnt_expired)
    );

    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tt_o1_d    = tt_o1_q;
        tt_o2_d    = tt_o2_q;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = DRIVE;
                    idx_d     = '0;
                    tt_o1_d   = '0;
                    tt_o2_d   = '0;
                    cnt_clear = 1'b1;
                end
            end
            DRIVE: begin
                cnt_enable = 1'b1;
                if (cnt_expired) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                // Capture the response present in this cycle, then move on;
                // the counter restarts from 0 for the next vector.
                tt_o1_d[idx_q] = O1;
                tt_o2_d[idx_q] = O2;
                cnt_clear      = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + TT_IDX_W'(1);
                    state_d = DRIVE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tt_o1_q <= '0;
            tt_o2_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tt_o1_q <= tt_o1_d;
            tt_o2_q <= tt_o2_d;
        end
    end

`ifdef TT_SWEEP_CHECK_EN
    logic mismatch_q, mismatch_d;

    // Compare the next-state tables so the final sample is included when
    // the result lands together with done.
    always_comb begin
        mismatch_d = mismatch_q;
        if (state_q != DONE && state_d == DONE) begin
            mismatch_d = (tt_o1_d != EXP_O1) || (tt_o2_d != EXP_O2);
        end else if (state_q == DONE && state_d != DONE) begin
            mismatch_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`else
    // Golden tables are only consumed by the checker; fold them into a
    // dangling net so the build without it stays warning-free.
    logic unused_exp;
    assign unused_exp = ^{EXP_O1, EXP_O2};
    assign mismatch   = 1'b0;
`endif

    assign {I1, I2, I3} = idx_q;
    assign idx          = idx_q;
    assign busy         = (state_q == DRIVE) || (state_q == SAMPLE);
    assign done         = (state_q == DONE);
    assign tt_o1        = tt_o1_q;
    assign tt_o2        = tt_o2_q;

endmodule : tt_sweep

// File: tb/tb_tt_sweep.sv
// -----------------------------------------------------------------------------
// tb_tt_sweep
// Two instances share clock and reset: dut1 (SETTLE_CYCLES=1) and dut3
// (SETTLE_CYCLES=3). Each drives a model of the lab block (O1 = majority,
// O2 = even parity, i.e. tables E8/69) with fault hooks. Expected completions
// are queued at start; monitors pop them when done rises and check tables,
// mismatch and the completion cycle. Honours TT_SWEEP_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_tt_sweep;

`ifdef TT_SWEEP_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    typedef struct {
        logic [7:0] t1;
        logic [7:0] t2;
        logic       mm;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    exp_t q1[$];
    exp_t q3[$];

    logic       start1, start3;
    logic       i1_1, i2_1, i3_1, o1_1, o2_1;
    logic       i1_3, i2_3, i3_3, o1_3, o2_3;
    logic [2:0] idx1, idx3;
    logic       busy1, busy3, done1, done3, mm1, mm3;
    logic [7:0] tt1_1, tt2_1, tt1_3, tt2_3;
    logic       stuck1 = 1'b0;
    logic       glitch3 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Lab block models: majority and even parity, with fault hooks.
    assign o1_1 = stuck1 ? 1'b0 : ((i1_1 & i2_1) | (i1_1 & i3_1) | (i2_1 & i3_1));
    assign o2_1 = ~(i1_1 ^ i2_1 ^ i3_1);
    assign o1_3 = (i1_3 & i2_3) | (i1_3 & i3_3) | (i2_3 & i3_3);
    assign o2_3 = glitch3 ^ ~(i1_3 ^ i2_3 ^ i3_3);

    tt_sweep #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .I1(i1_1), .I2(i2_1), .I3(i3_1), .O1(o1_1), .O2(o2_1),
        .idx(idx1), .busy(busy1), .done(done1),
        .tt_o1(tt1_1), .tt_o2(tt2_1), .mismatch(mm1)
    );

    tt_sweep #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .I1(i1_3), .I2(i2_3), .I3(i3_3), .O1(o1_3), .O2(o2_3),
        .idx(idx3), .busy(busy3), .done(done3),
        .tt_o1(tt1_3), .tt_o2(tt2_3), .mismatch(mm3)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: pop one expectation per rising edge of done.
    logic done1_prev = 1'b0;
    logic done3_prev = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            done1_prev <= 1'b0;
            done3_prev <= 1'b0;
        end else begin
            if (done1 && !done1_prev) begin
                if (q1.size() == 0) begin
                    check("dut1_unexpected_done", q1.size(), 1);
                end else begin
                    e = q1.pop_front();
                    check("dut1_tt_o1", tt1_1, e.t1);
                    check("dut1_tt_o2", tt2_1, e.t2);
                    check("dut1_mismatch", mm1, e.mm);
                    check("dut1_done_cycle", cyc, e.cyc);
                end
            end
            if (done3 && !done3_prev) begin
                if (q3.size() == 0) begin
                    check("dut3_unexpected_done", q3.size(), 1);
                end else begin
                    e = q3.pop_front();
                    check("dut3_tt_o1", tt1_3, e.t1);
                    check("dut3_tt_o2", tt2_3, e.t2);
                    check("dut3_mismatch", mm3, e.mm);
                    check("dut3_done_cycle", cyc, e.cyc);
                end
            end
            done1_prev <= done1;
            done3_prev <= done3;
        end
    end

    // One-cycle start pulse; returns the cycle number of the start edge.
    task automatic pulse1(output int n0);
        @(posedge clk);
        #1 start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        n0 = cyc;
    endtask

    task automatic drain1(input int budget);
        for (int i = 0; i < budget && q1.size() != 0; i++) @(posedge clk);
        check("dut1_done_timeout", q1.size(), 0);
        q1.delete();
    endtask

    task automatic drain3(input int budget);
        for (int i = 0; i < budget && q3.size() != 0; i++) @(posedge clk);
        check("dut3_done_timeout", q3.size(), 0);
        q3.delete();
    endtask

    initial begin
        int n0;
        rst_n  = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dut1_outputs", {idx1, i1_1, i2_1, i3_1, busy1, done1, mm1}, 0);
        check("rst_dut1_tables", {tt1_1, tt2_1}, 0);
        check("rst_dut3_outputs", {idx3, busy3, done3, mm3, tt1_3, tt2_3}, 0);
        rst_n = 1'b1;

        // Golden sweep, SETTLE_CYCLES=1: done 16 cycles after the start edge.
        pulse1(n0);
        q1.push_back('{t1: 8'hE8, t2: 8'h69, mm: 1'b0, cyc: n0 + 16});
        @(negedge clk);
        check("sweep_busy_after_start", {busy1, done1, idx1}, {1'b1, 1'b0, 3'd0});
        drain1(40);
        repeat (3) @(negedge clk);
        check("done_held_stable", {done1, busy1, tt1_1, tt2_1}, {1'b1, 1'b0, 8'hE8, 8'h69});

        // Start held high across the whole sweep: begins from DONE, no restart.
        @(posedge clk);
        #1 start1 = 1'b1;
        @(posedge clk);
        #1 n0 = cyc;
        q1.push_back('{t1: 8'hE8, t2: 8'h69, mm: 1'b0, cyc: n0 + 16});
        @(negedge clk);
        check("restart_clears_tables", {tt1_1, tt2_1}, 0);
        check("restart_done_low", {done1, busy1, idx1, mm1}, {1'b0, 1'b1, 3'd0, 1'b0});
        repeat (15) @(posedge clk);
        #1 start1 = 1'b0;
        drain1(40);

        // O1 stuck at 0: empty O1 table, checker flags it when compiled in.
        stuck1 = 1'b1;
        pulse1(n0);
        q1.push_back('{t1: 8'h00, t2: 8'h69, mm: CHK, cyc: n0 + 16});
        drain1(40);
        stuck1 = 1'b0;

        // SETTLE_CYCLES=3: each vector held 4 cycles; O2 disturbed during
        // the DRIVE cycles of vector 2 only, clean in its SAMPLE cycle.
        @(posedge clk);
        #1 start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
        n0 = cyc;
        q3.push_back('{t1: 8'hE8, t2: 8'h69, mm: 1'b0, cyc: n0 + 32});
        for (int j = 0; j < 32; j++) begin
            if (j > 0) begin
                @(posedge clk);
                #1;
            end
            glitch3 = (j >= 8 && j <= 10);
            @(negedge clk);
            check($sformatf("dut3_idx_j%0d", j), {busy3, idx3, i1_3, i2_3, i3_3},
                  {1'b1, 3'(j / 4), 3'(j / 4)});
        end
        drain3(20);

        // Asynchronous reset while dut1 drives vector 4.
        pulse1(n0);
        repeat (8) @(posedge clk);
        #1;
        check("pre_reset_idx", {busy1, idx1}, {1'b1, 3'd4});
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {idx1, i1_1, i2_1, i3_1, busy1, done1, mm1}, 0);
        check("async_reset_tables", {tt1_1, tt2_1}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_after_reset", {busy1, done1, idx1}, 0);
        check("queues_empty", q1.size() + q3.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_tt_sweep

// File: doc/tt_sweep.md
# tt_sweep

Sequential stimulus/capture stage wrapped around the 3-input, 2-output gate-level combinational lab block.
- Drives `I1`/`I2`/`I3` through all 8 input vectors in order, waits a programmable settle time, then samples `O1`/`O2`.
- Accumulates two 8-bit truth tables and reports completion.
- Optionally checks the captured tables against golden tables.
- Sits directly upstream (feeds inputs) and downstream (consumes outputs) of the combinational block on the lab board.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 1 — cycles each vector is held before sampling; legal range 1..15.
- `EXP_O1`, default 8'hE8 — golden `O1` truth table (bit i = response to vector i); used only with the checker.
- `EXP_O2`, default 8'h69 — golden `O2` truth table; used only with the checker.

Ports:
- `clk` input 1 — single clock, rising edge.
- `rst_n` input 1 — asynchronous, active-low reset.
- `start` input 1 — begin a sweep; sampled in IDLE or DONE only.
- `I1`, `I2`, `I3` output 1 each — drive vector; `{I1,I2,I3}` = `idx`.
- `O1`, `O2` input 1 each — combinational block responses.
- `idx` output 3 — current vector index.
- `busy` output 1 — high while sweeping.
- `done` output 1 — level; high from sweep completion until the next `start` or reset.
- `tt_o1`, `tt_o2` output 8 each — captured truth tables.
- `mismatch` output 1 — checker result; tied 0 when the checker is compiled out.

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- Reset (async, any state, including mid-sweep):
  - state=IDLE.
  - `idx`=0, `I1`/`I2`/`I3`=0.
  - `busy`=0, `done`=0, `mismatch`=0.
  - `tt_o1`=`tt_o2`=8'h00.
  - Settle counter=0.
- IDLE/DONE with `start`=1:
  - Next state DRIVE.
  - `idx`=0, counter=0.
  - Tables cleared to 0, `done`=0, `mismatch`=0, `busy`=1.
- DRIVE:
  - Hold vector `idx`; counter increments each cycle.
  - Go to SAMPLE in the cycle after counter reaches `SETTLE_CYCLES`-1.
- SAMPLE (one cycle):
  - On the rising edge leaving SAMPLE: `tt_o1[idx]`<=`O1`, `tt_o2[idx]`<=`O2`.
  - If `idx`==7: next state DONE, `busy`=0, `done`=1.
  - Otherwise: `idx`+1, counter=0, next state DRIVE.
- DONE: outputs and tables held stable until `start` or reset.
- `start` while busy (DRIVE/SAMPLE) is ignored; no restart and no effect on the sweep.
- `idx` never wraps within a sweep; 7→0 occurs only through a new `start`.
- Illegal or unencoded state: next state IDLE.

## Timing
- `I1`/`I2`/`I3` are registered; they change on the same edge that updates `idx`.
- Per vector: `SETTLE_CYCLES` DRIVE cycles + 1 SAMPLE cycle.
- Sweep latency from the `start` edge to `done` high: 8×(`SETTLE_CYCLES`+1) cycles. With default 1: 16 cycles.
- Tables are valid in the same cycle `done` rises.
- `mismatch` is valid in the same cycle `done` rises.

## Configuration
- Macro: `TT_SWEEP_CHECK_EN`.
- Defined:
  - On entering DONE, `mismatch` <= (`tt_o1`≠`EXP_O1`) | (`tt_o2`≠`EXP_O2`), evaluated with the final sample included.
  - `mismatch` is held with `done`.
- Undefined:
  - `mismatch` is constant 0.
  - No comparator logic; `EXP_O1`/`EXP_O2` are unused.

## Structure
- Package `tt_sweep_pkg`:
  - State enum `tt_state_t` (IDLE, DRIVE, SAMPLE, DONE).
  - `TT_NUM_VEC`=8, `TT_IDX_W`=3, `TT_CNT_W`=4.
- One sub-module, `tt_settle_cnt`:
  - 4-bit settle counter.
  - Inputs: `clear`, `enable`.
  - Output: `expired` when count==`SETTLE_CYCLES`-1.
  - Async active-low reset.
- The FSM, index and table registers stay in `tt_sweep`.

## Test plan
- Reset mid-sweep: assert `rst_n`=0 while `idx`=4 in DRIVE -> all outputs 0 immediately, without waiting for a clock edge; IDLE after release.
- Golden DUT, `SETTLE_CYCLES`=1: one-cycle `start` pulse -> `done` high exactly 16 cycles later; `tt_o1`=8'hE8, `tt_o2`=8'h69; `mismatch`=0.
- Model `O1` stuck-at-0, checker defined -> `tt_o1`=8'h00, `mismatch`=1 at `done`; checker undefined -> `mismatch`=0.
- `SETTLE_CYCLES`=3: `start` -> each vector held 4 cycles; `idx` sequence 0..7; `done` at cycle 32.
- `start` asserted continuously during a sweep -> no restart, `done` at cycle 16; a `start` in DONE -> tables cleared to 0, new sweep begins, `done` low next cycle.
- Tables reflect the `O1`/`O2` value present in SAMPLE: toggle `O2` in DRIVE only for vector 2 -> `tt_o2[2]` equals the SAMPLE-cycle value.
